stepper_sequencer: RTL and testbench
====================================

# stepper_sequencer

Generates the 4-bit full-step phase pattern that drives the elevator's stepper motor and that the motor_encoder stage decodes back into a 2-bit motor state. It accepts a move command (direction, step count) through a valid/ready handshake. It paces steps with a programmable clock divider and reports completion with a one-cycle done pulse. It sits between the elevator control FSM (upstream) and the motor driver/encoder (downstream).

## Interface
- STEP_DIV, 50000, clock cycles per motor step; legal range ≥2.
- CNT_W, 16, width of the step count and remaining-steps counter.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  a move command is presented.
- cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
- cmd_dir  input  1  direction; 1 = up (phase index +1), 0 = down (phase index −1).
- cmd_steps  input  CNT_W  number of full steps to take; 0 is legal.
- abort  input  1  stop the current move at the next edge.
- motor_signals  output  4  registered phase pattern to the motor driver and encoder.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a command completes or is aborted.
- steps_left  output  CNT_W  remaining steps of the current or last command.

## Operation
- Phase index p (2 bits) maps to motor_signals as follows: p=0 → 1001, p=1 → 1100, p=2 → 0110, p=3 → 0011.
- Phase stepping:
  - Up: p+1 mod 4, so 0011 wraps to 1001.
  - Down: p−1 mod 4, so 1001 wraps to 0011.
- No other pattern is ever driven. motor_signals holds its last value while idle (holding torque).
- Reset values: p=0 (motor_signals=1001), state IDLE, cmd_ready=1, busy=0, done=0, steps_left=0, divider=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid=1, the command is accepted; dir is latched and steps_left ← cmd_steps.
    - If cmd_steps≠0, go to RUN with divider cleared.
    - If cmd_steps=0, go to DONE with no phase change.
  - RUN: busy=1, cmd_ready=0. The divider counts 0..STEP_DIV−1.
    - When the divider reaches STEP_DIV−1, it returns to 0, p steps in the latched direction, and steps_left decrements.
    - If steps_left decrements to 0, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0. Always returns to IDLE.
- Abort:
  - Sampled only in RUN. When abort=1, go to DONE at that edge.
  - No phase advance at that edge, even if the divider is at terminal count.
  - steps_left keeps its unexecuted count (nonzero) and the divider clears.
  - abort is ignored in IDLE and DONE.
- cmd_valid is ignored outside IDLE. cmd_dir and cmd_steps are sampled only at acceptance.
- steps_left arithmetic is unsigned CNT_W. It never underflows, because a decrement happens only when it is ≥1.

## Timing
- Acceptance: cmd_valid & cmd_ready at rising edge N.
- Steps: first motor_signals change visible after edge N+STEP_DIV; step k after edge N+k·STEP_DIV.
- Completion: last step at edge N+S·STEP_DIV (S = cmd_steps); done is high in the following cycle; cmd_ready returns one cycle after that. Total command-to-ready time is S·STEP_DIV+2 cycles.
- Zero-step command: done is high the cycle after acceptance; cmd_ready returns the cycle after that.
- Back-to-back commands: the earliest next acceptance is the first cycle cmd_ready=1 after done.
- Asynchronous reset: asserting reset mid-RUN forces the reset values immediately. In particular motor_signals=1001 without waiting for a clock, and no done pulse is generated. Deassertion is synchronized by the integrator.
- The downstream motor_encoder therefore reads state 00 after reset and changes by ±1 mod 4 at most once per STEP_DIV cycles.

## Test plan
- Reset: assert reset asynchronously mid-RUN → motor_signals=1001, busy=0, done=0, cmd_ready=1, steps_left=0 immediately.
- Up move with STEP_DIV=4, cmd_dir=1, cmd_steps=5 from reset:
  - Patterns 1100, 0110, 0011, 1001, 1100 appear at edges N+4, N+8, N+12, N+16, N+20.
  - done is high at cycle N+21 only; steps_left ends at 0.
- Down move with cmd_dir=0, cmd_steps=3 from p=0 → 0011, 0110, 1100 (wrap-around), one done pulse.
- Zero steps: cmd_steps=0 → no motor_signals change; done pulses at N+1; cmd_ready=1 at N+2.
- Abort cases with cmd_steps=10, STEP_DIV=4:
  - abort at edge N+9 → two steps taken, steps_left=8, done the following cycle.
  - abort coincident with terminal count at edge N+12 → no third step, steps_left=8.
- Handshake: hold cmd_valid=1 continuously with two queued commands → second is accepted exactly one cycle after done; cmd_valid during RUN changes nothing.

Source files
------------

// File: rtl/stepper_sequencer_if.sv
// ---------------------------------------------------------------------------
// stepper_sequencer_if
// Groups the command handshake and the motor-side status of the stepper
// sequencer.
//   master : upstream controller (drives command and abort, reads status)
//   slave  : the sequencer itself
// Signals:
//   cmd_valid / cmd_ready  move-command handshake
//   cmd_dir                1 = up (phase +1), 0 = down (phase -1)
//   cmd_steps              number of full steps in the command
//   abort                  stop the running move
//   motor_signals          4-bit full-step phase pattern
//   busy / done            move in progress / one-cycle completion pulse
//   steps_left             remaining steps of current or last command
// ---------------------------------------------------------------------------
interface stepper_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic             abort;
  logic [3:0]       motor_signals;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, abort,
    input  cmd_ready, motor_signals, busy, done, steps_left
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, abort,
    output cmd_ready, motor_signals, busy, done, steps_left
  );
endinterface

// File: rtl/stepper_sequencer.sv
// ---------------------------------------------------------------------------
// stepper_sequencer
// Accepts a move command (direction, step count), paces full steps with a
// clock divider of STEP_DIV cycles per step and drives the registered 4-bit
// phase pattern to the motor driver / encoder. A one-cycle done pulse marks
// completion or abort.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   sif    stepper_sequencer_if.slave (command handshake, abort, status)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a command, cmd_ready=1, pattern held
// S_RUN  | divider running, one phase step per STEP_DIV cycles
// S_DONE | one-cycle done pulse, then back to S_IDLE
// ---------------------------------------------------------------------------
module stepper_sequencer #(
  parameter int STEP_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  stepper_sequencer_if.slave  sif
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_phase;
  logic [3:0]       r_motor;
  logic             r_dir;
  logic [CNT_W-1:0] r_steps_left;
  logic [DIV_W-1:0] r_div;

  logic             w_tc;
  logic             w_step;
  logic [1:0]       w_phase_nxt;

  function automatic logic [3:0] phase_pattern(input logic [1:0] p);
    case (p)
      2'd0:    phase_pattern = 4'b1001;
      2'd1:    phase_pattern = 4'b1100;
      2'd2:    phase_pattern = 4'b0110;
      default: phase_pattern = 4'b0011;
    endcase
  endfunction

  assign w_tc        = (r_div == DIV_TC);
  // Abort wins over a coincident terminal count: no step on that edge.
  assign w_step      = (r_state == S_RUN) && !sif.abort && w_tc &&
                       (r_steps_left != '0);
  assign w_phase_nxt = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (sif.cmd_valid)
          w_next_state = (sif.cmd_steps == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (sif.abort)
          w_next_state = S_DONE;
        else if (w_step && (r_steps_left == CNT_W'(1)))
          w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase      <= 2'd0;
      r_motor      <= 4'b1001;
      r_dir        <= 1'b0;
      r_steps_left <= '0;
      r_div        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sif.cmd_valid) begin
            r_dir        <= sif.cmd_dir;
            r_steps_left <= sif.cmd_steps;
            r_div        <= '0;
          end
        end
        S_RUN: begin
          if (sif.abort || w_tc) begin
            r_div <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
          if (w_step) begin
            r_phase      <= w_phase_nxt;
            r_motor      <= phase_pattern(w_phase_nxt);
            r_steps_left <= r_steps_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sif.cmd_ready     = (r_state == S_IDLE);
  assign sif.busy          = (r_state == S_RUN);
  assign sif.done          = (r_state == S_DONE);
  assign sif.motor_signals = r_motor;
  assign sif.steps_left    = r_steps_left;

endmodule

// File: tb/tb_stepper_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stepper_sequencer
// Directed bench for stepper_sequencer with STEP_DIV=4. Expected phase
// patterns (with their cycle of appearance) and done-pulse cycles are pushed
// to queues when a command is issued; a negedge monitor pops and compares
// whenever motor_signals changes or done is high.
// ---------------------------------------------------------------------------
module tb_stepper_sequencer;
  localparam int DIV = 4;
  localparam int W   = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stepper_sequencer_if #(.CNT_W(W)) sif ();

  stepper_sequencer #(.STEP_DIV(DIV), .CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  typedef struct {
    int         t;
    logic [3:0] pat;
  } step_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  step_t      step_q[$];
  int         done_q[$];
  logic [1:0] tb_p;
  logic [3:0] prev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] pat(input logic [1:0] p);
    case (p)
      2'd0:    pat = 4'b1001;
      2'd1:    pat = 4'b1100;
      2'd2:    pat = 4'b0110;
      default: pat = 4'b0011;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    step_t e;
    int    td;
    if (reset) begin
      prev = sif.motor_signals;
    end else begin
      if (sif.motor_signals !== prev) begin
        chk("step_expected", 32'(step_q.size() != 0), 32'd1);
        if (step_q.size() != 0) begin
          e = step_q.pop_front();
          chk("step_pattern", 32'(sif.motor_signals), 32'(e.pat));
          chk("step_cycle", 32'(cyc), 32'(e.t));
        end
        prev = sif.motor_signals;
      end
      if (sif.done === 1'b1) begin
        chk("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          td = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(td));
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Push nexec steps of the bench phase model and the done cycle.
  task automatic expect_move(input logic dir, input int nexec, input int n, input int tdone);
    step_t e;
    for (int k = 1; k <= nexec; k++) begin
      tb_p  = dir ? tb_p + 2'd1 : tb_p - 2'd1;
      e.t   = n + DIV * k;
      e.pat = pat(tb_p);
      step_q.push_back(e);
    end
    done_q.push_back(tdone);
  endtask

  // Called at a negedge; returns the acceptance edge number.
  task automatic issue(input logic dir, input int steps, output int n);
    int k;
    k = 0;
    while (sif.cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_cmd", 32'(sif.cmd_ready), 32'd1);
    sif.cmd_dir   = dir;
    sif.cmd_steps = W'(steps);
    sif.cmd_valid = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    sif.cmd_valid = 1'b0;
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_steps_pending"}, 32'(step_q.size()), 32'd0);
    chk({tag, "_done_pending"}, 32'(done_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_motor"}, 32'(sif.motor_signals), 32'h9);
    chk({tag, "_ready"}, 32'(sif.cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
    chk({tag, "_done"}, 32'(sif.done), 32'd0);
    chk({tag, "_steps_left"}, 32'(sif.steps_left), 32'd0);
  endtask

  initial begin
    int n, n2;
    sif.cmd_valid = 1'b0;
    sif.cmd_dir   = 1'b0;
    sif.cmd_steps = '0;
    sif.abort     = 1'b0;
    tb_p          = 2'd0;

    #12;
    check_reset_values("por");
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);

    // Up move, 5 steps: 1100 0110 0011 1001 1100
    issue(1'b1, 5, n);
    expect_move(1'b1, 5, n, n + 5 * DIV);
    wait_cyc(n + 2);
    chk("up_busy", 32'(sif.busy), 32'd1);
    chk("up_ready_low", 32'(sif.cmd_ready), 32'd0);
    wait_cyc(n + 5 * DIV + 1);
    queues_empty("up");
    chk("up_steps_left", 32'(sif.steps_left), 32'd0);
    chk("up_ready_back", 32'(sif.cmd_ready), 32'd1);

    // Asynchronous reset mid-run
    issue(1'b1, 10, n);
    expect_move(1'b1, 10, n, n + 10 * DIV);
    wait_cyc(n + 6);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    step_q.delete();
    done_q.delete();
    tb_p = 2'd0;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // Down move, 3 steps from p=0: 0011 0110 1100
    issue(1'b0, 3, n);
    expect_move(1'b0, 3, n, n + 3 * DIV);
    wait_cyc(n + 3 * DIV + 1);
    queues_empty("down");
    chk("down_steps_left", 32'(sif.steps_left), 32'd0);

    // Zero-step command
    issue(1'b1, 0, n);
    expect_move(1'b1, 0, n, n);
    chk("zero_ready_low", 32'(sif.cmd_ready), 32'd0);
    chk("zero_busy", 32'(sif.busy), 32'd0);
    wait_cyc(n + 1);
    chk("zero_ready_back", 32'(sif.cmd_ready), 32'd1);
    queues_empty("zero");

    // Abort is ignored while idle
    sif.abort = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("idle_abort_ready", 32'(sif.cmd_ready), 32'd1);
    chk("idle_abort_busy", 32'(sif.busy), 32'd0);
    sif.abort = 1'b0;
    @(negedge clk);

    // Abort at edge N+9: two steps taken
    issue(1'b1, 10, n);
    expect_move(1'b1, 2, n, n + 9);
    wait_cyc(n + 8);
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    chk("abort9_steps_left", 32'(sif.steps_left), 32'd8);
    chk("abort9_busy", 32'(sif.busy), 32'd0);
    wait_cyc(n + 11);
    queues_empty("abort9");
    chk("abort9_steps_left_hold", 32'(sif.steps_left), 32'd8);

    // Abort coincident with terminal count at edge N+12
    issue(1'b0, 10, n);
    expect_move(1'b0, 2, n, n + 12);
    wait_cyc(n + 11);
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    chk("abort12_steps_left", 32'(sif.steps_left), 32'd8);
    wait_cyc(n + 3 * DIV + 2);
    queues_empty("abort12");

    // Handshake: cmd_valid held high across two commands
    wait_cyc(cyc + 1);
    sif.cmd_dir   = 1'b1;
    sif.cmd_steps = W'(2);
    sif.cmd_valid = 1'b1;
    n = cyc + 1;
    expect_move(1'b1, 2, n, n + 2 * DIV);
    @(negedge clk);
    sif.cmd_dir   = 1'b0;
    sif.cmd_steps = W'(1);
    n2 = n + 2 * DIV + 2;
    expect_move(1'b0, 1, n2, n2 + DIV);
    wait_cyc(n + 5);
    chk("hs_run_steps_left", 32'(sif.steps_left), 32'd1);
    chk("hs_run_ready", 32'(sif.cmd_ready), 32'd0);
    wait_cyc(n2);
    chk("hs_second_accepted_busy", 32'(sif.busy), 32'd1);
    sif.cmd_valid = 1'b0;
    wait_cyc(n2 + DIV + 2);
    queues_empty("hs");
    chk("hs_steps_left", 32'(sif.steps_left), 32'd0);
    chk("hs_ready_back", 32'(sif.cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
